// File: rtl/pipe_pkg.sv
// Shared constants for the ID->EX skid stage: ctrl bundle layout, bubble encoding,
// occupancy states and the operand slice helper.
package pipe_pkg;

  localparam int CTRL_NPC_OP_LSB = 0;
  localparam int CTRL_NPC_OP_W   = 3;
  localparam int CTRL_ALUOP_LSB  = 3;
  localparam int CTRL_ALUOP_W    = 4;
  localparam int CTRL_RF_WE_BIT  = 7;
  localparam int CTRL_DRAM_WE_BIT = 8;
  localparam int CTRL_WB_SEL_LSB = 9;
  localparam int CTRL_WB_SEL_W   = 2;

  // Every ctrl bit at this value marks a bubble; EX treats it as a no-op.
  localparam logic CTRL_BUBBLE = 1'b0;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  function automatic int op_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One held pipeline entry: valid, control bundle and payload, with load and clear.
import pipe_pkg::*;

module pipe_slot #(
  parameter int CTRL_W  = 16,
  parameter int DATA_W  = 32,
  parameter int NUM_OPS = 2,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      load,
  input  logic                      d_valid,
  input  logic [CTRL_W-1:0]         d_ctrl,
  input  logic [DATA_W-1:0]         d_pc,
  input  logic [DATA_W-1:0]         d_pc4,
  input  logic [DATA_W-1:0]         d_imm,
  input  logic [NUM_OPS*DATA_W-1:0] d_ops,
  input  logic [ADDR_W-1:0]         d_waddr,
  output logic                      q_valid,
  output logic [CTRL_W-1:0]         q_ctrl,
  output logic [DATA_W-1:0]         q_pc,
  output logic [DATA_W-1:0]         q_pc4,
  output logic [DATA_W-1:0]         q_imm,
  output logic [NUM_OPS*DATA_W-1:0] q_ops,
  output logic [ADDR_W-1:0]         q_waddr
);

  // Clear only kills valid and ctrl; stale payload is harmless once ctrl is a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_pc    <= '0;
      q_pc4   <= '0;
      q_imm   <= '0;
      q_ops   <= '0;
      q_waddr <= '0;
    end else if (clr) begin
      q_valid <= 1'b0;
      q_ctrl  <= {CTRL_W{CTRL_BUBBLE}};
    end else if (load) begin
      q_valid <= d_valid;
      q_ctrl  <= d_valid ? d_ctrl : {CTRL_W{CTRL_BUBBLE}};
      q_pc    <= d_pc;
      q_pc4   <= d_pc4;
      q_imm   <= d_imm;
      q_ops   <= d_ops;
      q_waddr <= d_waddr;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// ID->EX stage register with a 2-entry skid buffer, flush and operand forwarding capture.
//   state     | meaning
//   OCC_EMPTY | nothing held, out_valid=0
//   OCC_ONE   | main holds an entry, skid free
//   OCC_TWO   | main and skid both hold entries, in_ready=0
import pipe_pkg::*;

module pipe_stage_skid #(
  parameter int CTRL_W  = 16,
  parameter int DATA_W  = 32,
  parameter int NUM_OPS = 2,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [DATA_W-1:0]         in_pc,
  input  logic [DATA_W-1:0]         in_pc4,
  input  logic [DATA_W-1:0]         in_imm,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  input  logic [ADDR_W-1:0]         in_waddr,
  input  logic [NUM_OPS-1:0]        fwd_sel,
  input  logic [NUM_OPS*DATA_W-1:0] fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [DATA_W-1:0]         out_pc,
  output logic [DATA_W-1:0]         out_pc4,
  output logic [DATA_W-1:0]         out_imm,
  output logic [NUM_OPS*DATA_W-1:0] out_ops,
  output logic [ADDR_W-1:0]         out_waddr,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic [1:0]                occ;
  logic                      accept;
  logic                      main_load;
  logic                      skid_load;
  logic [NUM_OPS*DATA_W-1:0] cap_ops;

  logic                      main_valid;
  logic [CTRL_W-1:0]         main_ctrl;
  logic                      main_d_valid;
  logic [CTRL_W-1:0]         main_d_ctrl;
  logic [DATA_W-1:0]         main_d_pc;
  logic [DATA_W-1:0]         main_d_pc4;
  logic [DATA_W-1:0]         main_d_imm;
  logic [NUM_OPS*DATA_W-1:0] main_d_ops;
  logic [ADDR_W-1:0]         main_d_waddr;

  logic                      skid_valid;
  logic [CTRL_W-1:0]         skid_ctrl;
  logic [DATA_W-1:0]         skid_pc;
  logic [DATA_W-1:0]         skid_pc4;
  logic [DATA_W-1:0]         skid_imm;
  logic [NUM_OPS*DATA_W-1:0] skid_ops;
  logic [ADDR_W-1:0]         skid_waddr;

  // Forwarding is resolved once, at capture; held entries never look at fwd_* again.
  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    assign cap_ops[op_lsb(i, DATA_W) +: DATA_W] = fwd_sel[i] ? fwd_data[op_lsb(i, DATA_W) +: DATA_W]
                                                             : in_ops[op_lsb(i, DATA_W) +: DATA_W];
  end

  assign occ       = skid_valid ? OCC_TWO : (main_valid ? OCC_ONE : OCC_EMPTY);
  assign in_ready  = (occ != OCC_TWO);
  assign accept    = in_valid & in_ready;
  assign main_load = (occ == OCC_EMPTY) | out_ready;
  // In OCC_TWO the skid drains into main whenever EX consumes; otherwise it catches a stalled accept.
  assign skid_load = (occ == OCC_TWO) ? out_ready
                                      : ((occ == OCC_ONE) & ~out_ready & accept);

  assign main_d_valid = skid_valid | accept;
  assign main_d_ctrl  = skid_valid ? skid_ctrl  : in_ctrl;
  assign main_d_pc    = skid_valid ? skid_pc    : in_pc;
  assign main_d_pc4   = skid_valid ? skid_pc4   : in_pc4;
  assign main_d_imm   = skid_valid ? skid_imm   : in_imm;
  assign main_d_ops   = skid_valid ? skid_ops   : cap_ops;
  assign main_d_waddr = skid_valid ? skid_waddr : in_waddr;

  pipe_slot #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .ADDR_W(ADDR_W)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .load    (main_load),
    .d_valid (main_d_valid),
    .d_ctrl  (main_d_ctrl),
    .d_pc    (main_d_pc),
    .d_pc4   (main_d_pc4),
    .d_imm   (main_d_imm),
    .d_ops   (main_d_ops),
    .d_waddr (main_d_waddr),
    .q_valid (main_valid),
    .q_ctrl  (main_ctrl),
    .q_pc    (out_pc),
    .q_pc4   (out_pc4),
    .q_imm   (out_imm),
    .q_ops   (out_ops),
    .q_waddr (out_waddr)
  );

  pipe_slot #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .ADDR_W(ADDR_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .load    (skid_load),
    .d_valid (accept),
    .d_ctrl  (in_ctrl),
    .d_pc    (in_pc),
    .d_pc4   (in_pc4),
    .d_imm   (in_imm),
    .d_ops   (cap_ops),
    .d_waddr (in_waddr),
    .q_valid (skid_valid),
    .q_ctrl  (skid_ctrl),
    .q_pc    (skid_pc),
    .q_pc4   (skid_pc4),
    .q_imm   (skid_imm),
    .q_ops   (skid_ops),
    .q_waddr (skid_waddr)
  );

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : {CTRL_W{CTRL_BUBBLE}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid; a second instance with a 4-bit stall counter shares the stimulus.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [15:0] in_ctrl;
  logic [31:0] in_pc, in_pc4, in_imm;
  logic [63:0] in_ops, fwd_data;
  logic [4:0]  in_waddr;
  logic [1:0]  fwd_sel;

  logic        in_ready, out_valid;
  logic [15:0] out_ctrl, stall_cnt;
  logic [31:0] out_pc, out_pc4, out_imm;
  logic [63:0] out_ops;
  logic [4:0]  out_waddr;

  logic        s_in_ready, s_out_valid;
  logic [15:0] s_out_ctrl;
  logic [31:0] s_out_pc, s_out_pc4, s_out_imm;
  logic [63:0] s_out_ops;
  logic [4:0]  s_out_waddr;
  logic [3:0]  s_stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_pc(in_pc), .in_pc4(in_pc4), .in_imm(in_imm), .in_ops(in_ops),
    .in_waddr(in_waddr), .fwd_sel(fwd_sel), .fwd_data(fwd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_pc(out_pc), .out_pc4(out_pc4),
    .out_imm(out_imm), .out_ops(out_ops), .out_waddr(out_waddr), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_pc(in_pc), .in_pc4(in_pc4), .in_imm(in_imm), .in_ops(in_ops),
    .in_waddr(in_waddr), .fwd_sel(fwd_sel), .fwd_data(fwd_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_pc(s_out_pc), .out_pc4(s_out_pc4),
    .out_imm(s_out_imm), .out_ops(s_out_ops), .out_waddr(s_out_waddr), .stall_cnt(s_stall_cnt)
  );

  typedef struct packed {
    logic [15:0] ctrl;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [63:0] ops;
    logic [4:0]  waddr;
  } ent_t;

  ent_t exp_q[$];
  ent_t obs_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic acc_d;

  // Drives one cycle starting at a negedge; returns at the following negedge.
  task automatic tick(input logic v, input logic [31:0] pc, input logic [63:0] ops,
                      input logic [1:0] fs, input logic [63:0] fd, input logic ordy,
                      input logic fl, output logic acc);
    ent_t e;
    in_valid  = v;
    in_pc     = pc;
    in_pc4    = pc + 32'd4;
    in_imm    = pc ^ 32'hA5A5_0000;
    in_ctrl   = 16'h8000 | pc[15:0];
    in_ops    = ops;
    in_waddr  = pc[6:2];
    fwd_sel   = fs;
    fwd_data  = fd;
    out_ready = ordy;
    flush     = fl;
    #1;
    acc = v && in_ready && !fl;
    if (acc) begin
      e.ctrl        = in_ctrl;
      e.pc          = in_pc;
      e.pc4         = in_pc4;
      e.imm         = in_imm;
      e.waddr       = in_waddr;
      e.ops[31:0]   = fs[0] ? fd[31:0]  : ops[31:0];
      e.ops[63:32]  = fs[1] ? fd[63:32] : ops[63:32];
      exp_q.push_back(e);
    end
    if (out_valid && ordy && !fl)
      obs_q.push_back({out_ctrl, out_pc, out_pc4, out_imm, out_ops, out_waddr});
    @(posedge clk);
    if (fl) exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_pc = '0; in_pc4 = '0; in_imm = '0; in_ops = '0;
    in_waddr = '0; fwd_sel = '0; fwd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_assert++; if (out_ctrl !== 16'h0) begin n_fail++; $display("FAIL reset_out_ctrl: got %h want 0000", out_ctrl); end
    n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_assert++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    n_assert++; if (s_stall_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_sat_stall_cnt: got %0d want 0", s_stall_cnt); end
  endtask

  task automatic test_stream();
    ent_t o, e;
    int   got;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 32'(4 * k), {32'(k + 100), 32'(k)}, 2'b00, 64'h0, 1'b1, 1'b0, acc_d);
      n_assert++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin
        n_fail++; $display("FAIL stream_latency: cycle %0d got valid=%b pc=%h want valid=1 pc=%h", k, out_valid, out_pc, 32'(4 * k));
      end
    end
    tick(1'b0, 32'h0, 64'h0, 2'b00, 64'h0, 1'b1, 1'b0, acc_d);
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got valid=%b want 0", out_valid); end
    got = obs_q.size();
    n_assert++; if (got != 8) begin n_fail++; $display("FAIL stream_count: got %0d entries want 8", got); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL stream_entry: got pc=%h ops=%h ctrl=%h want pc=%h ops=%h ctrl=%h", o.pc, o.ops, o.ctrl, e.pc, e.ops, e.ctrl); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_pressure();
    ent_t o, e;
    int   idx, got;
    logic acc, ordy;
    logic [15:0] base;
    logic [3:0]  s_base;
    base = stall_cnt; s_base = s_stall_cnt; idx = 0;
    for (int c = 0; c < 40 && obs_q.size() < 6; c++) begin
      ordy = !(c >= 1 && c <= 3);
      tick(idx < 6, 32'h100 + 32'(4 * idx), {32'(idx + 32'h1000), 32'(idx + 32'h2000)}, 2'b00, 64'h0, ordy, 1'b0, acc);
      if (acc) idx++;
      if (c == 1) begin
        n_assert++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_drop: got %b want 0", in_ready); end
      end
      if (c == 3) begin
        n_assert++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin n_fail++; $display("FAIL bp_hold: got valid=%b pc=%h want valid=1 pc=00000100", out_valid, out_pc); end
      end
    end
    n_assert++; if (stall_cnt - base !== 16'd3) begin n_fail++; $display("FAIL bp_stall_cnt: got delta %0d want 3", stall_cnt - base); end
    n_assert++; if (s_stall_cnt - s_base !== 4'd3) begin n_fail++; $display("FAIL bp_sat_stall_cnt: got delta %0d want 3", s_stall_cnt - s_base); end
    got = obs_q.size();
    n_assert++; if (got != 6) begin n_fail++; $display("FAIL bp_count: got %0d entries want 6", got); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL bp_entry: got pc=%h ops=%h want pc=%h ops=%h", o.pc, o.ops, e.pc, e.ops); end
    end
    n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_leftover: got %0d unconsumed want 0", exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_forwarding();
    ent_t o, e;
    int   got;
    tick(1'b1, 32'h600, {32'h22, 32'h11}, 2'b01, {32'hBB, 32'hAA}, 1'b1, 1'b0, acc_d);
    tick(1'b0, 32'h0, 64'h0, 2'b11, {32'hDEAD, 32'hBEEF}, 1'b0, 1'b0, acc_d);
    n_assert++; if (out_ops !== {32'h22, 32'hAA}) begin n_fail++; $display("FAIL fwd_op0: got %h want 00000022000000aa", out_ops); end
    tick(1'b1, 32'h604, {32'h44, 32'h33}, 2'b10, {32'hCC, 32'hDD}, 1'b1, 1'b0, acc_d);
    n_assert++; if (out_ops !== {32'hCC, 32'h33}) begin n_fail++; $display("FAIL fwd_op1: got %h want 000000cc00000033", out_ops); end
    tick(1'b1, 32'h608, {32'h66, 32'h55}, 2'b11, {32'hEE, 32'hFF}, 1'b0, 1'b0, acc_d);
    tick(1'b0, 32'h0, 64'h0, 2'b11, {32'h1, 32'h2}, 1'b1, 1'b0, acc_d);
    n_assert++; if (out_ops !== {32'hEE, 32'hFF}) begin n_fail++; $display("FAIL fwd_skid: got %h want 000000ee000000ff", out_ops); end
    tick(1'b0, 32'h0, 64'h0, 2'b00, 64'h0, 1'b1, 1'b0, acc_d);
    got = obs_q.size();
    n_assert++; if (got != 3) begin n_fail++; $display("FAIL fwd_count: got %0d entries want 3", got); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL fwd_entry: got pc=%h ops=%h want pc=%h ops=%h", o.pc, o.ops, e.pc, e.ops); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_flush();
    ent_t o, e;
    int   got;
    logic [15:0] base;
    base = stall_cnt;
    tick(1'b1, 32'h200, 64'h1, 2'b00, 64'h0, 1'b1, 1'b0, acc_d);
    tick(1'b1, 32'h204, 64'h2, 2'b00, 64'h0, 1'b0, 1'b0, acc_d);
    n_assert++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_skid_full: got in_ready=%b want 0", in_ready); end
    tick(1'b1, 32'h208, 64'h3, 2'b00, 64'h0, 1'b0, 1'b1, acc_d);
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    n_assert++; if (out_ctrl !== 16'h0) begin n_fail++; $display("FAIL flush_out_ctrl: got %h want 0000", out_ctrl); end
    n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    n_assert++; if (stall_cnt - base !== 16'd2) begin n_fail++; $display("FAIL flush_stall_kept: got delta %0d want 2", stall_cnt - base); end
    tick(1'b1, 32'h300, 64'h4, 2'b00, 64'h0, 1'b0, 1'b0, acc_d);
    tick(1'b1, 32'h304, 64'h5, 2'b00, 64'h0, 1'b0, 1'b1, acc_d);
    tick(1'b0, 32'h0, 64'h0, 2'b00, 64'h0, 1'b1, 1'b0, acc_d);
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard_accept: got out_valid=%b pc=%h want 0", out_valid, out_pc); end
    tick(1'b1, 32'h400, 64'h6, 2'b00, 64'h0, 1'b1, 1'b0, acc_d);
    tick(1'b0, 32'h0, 64'h0, 2'b00, 64'h0, 1'b1, 1'b0, acc_d);
    got = obs_q.size();
    n_assert++; if (got != 1) begin n_fail++; $display("FAIL flush_count: got %0d entries want 1", got); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL flush_entry: got pc=%h want pc=%h", o.pc, e.pc); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_saturation();
    ent_t o, e;
    logic [15:0] base;
    base = stall_cnt;
    if (base < 16'd15) begin
      n_assert++; if (s_stall_cnt !== base[3:0]) begin n_fail++; $display("FAIL sat_track: got %0d want %0d", s_stall_cnt, base[3:0]); end
    end
    tick(1'b1, 32'h500, 64'h7, 2'b00, 64'h0, 1'b0, 1'b0, acc_d);
    for (int c = 0; c < 20; c++) tick(1'b0, 32'h0, 64'h0, 2'b00, 64'h0, 1'b0, 1'b0, acc_d);
    n_assert++; if (s_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_stall_cnt: got %0d want 15", s_stall_cnt); end
    n_assert++; if (stall_cnt - base !== 16'd20) begin n_fail++; $display("FAIL sat_wide_cnt: got delta %0d want 20", stall_cnt - base); end
    tick(1'b0, 32'h0, 64'h0, 2'b00, 64'h0, 1'b1, 1'b0, acc_d);
    n_assert++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL sat_count: got %0d entries want 1", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL sat_entry: got pc=%h want pc=%h", o.pc, e.pc); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_forwarding();
    test_flush();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
